// File: rtl/imm_ext_pkg.sv
// Shared widths, mode encodings and helpers for the pipelined immediate extender.
package imm_ext_pkg;

    localparam int unsigned IMM_IN_W   = 27;
    localparam int unsigned IMM_OUT_W  = 32;
    localparam int unsigned IMM_SH_W   = 5;
    localparam int unsigned IMM_BITS_W = 5;

    typedef enum logic [1:0] {
        IMM_SEXT     = 2'b00,
        IMM_ZEXT     = 2'b01,
        IMM_SEXT_SHL = 2'b10,
        IMM_RSVD     = 2'b11
    } imm_mode_t;

    // True for the mode whose result is left-shifted in the second stage.
    function automatic logic imm_is_shift(input imm_mode_t mode);
        return mode == IMM_SEXT_SHL;
    endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Stage-1 combinational logic: clamp the field width, mask the raw field, then sign- or zero-extend it.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = IMM_IN_W,
    parameter int unsigned OUT_W = IMM_OUT_W
) (
    input  logic [IN_W-1:0]       data,
    input  logic [IMM_BITS_W-1:0] bits,
    input  imm_mode_t             mode,
    output logic [OUT_W-1:0]      ext_data_c,
    output logic                  ext_err_c
);

    logic                  range_err;
    logic [IMM_BITS_W-1:0] eff_bits;
    logic [IN_W-1:0]       keep;
    logic [IN_W-1:0]       masked;
    logic                  sign;

    // A zero or oversized width falls back to the full field and flags the result.
    assign range_err = (bits == '0) || (32'(bits) > IN_W);
    assign eff_bits  = range_err ? IMM_BITS_W'(IN_W) : bits;

    assign keep   = ~({IN_W{1'b1}} << eff_bits);
    assign masked = data & keep;
    assign sign   = |(data & (IN_W'(1) << (eff_bits - IMM_BITS_W'(1))));

    always_comb begin
        ext_data_c = '0;
        ext_err_c  = range_err;
        case (mode)
            IMM_SEXT, IMM_SEXT_SHL: begin
                ext_data_c = sign ? (OUT_W'(masked) | ~OUT_W'(keep)) : OUT_W'(masked);
            end
            IMM_ZEXT: begin
                ext_data_c = OUT_W'(masked);
            end
            default: begin
                ext_data_c = '0;
                ext_err_c  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage valid/ready immediate extender: stage 1 masks/extends, stage 2 shifts and holds the result.
// Optional feature macro IMM_EXT_OVF_EN adds the out_ovf shift-overflow flag.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = IMM_IN_W,
    parameter int unsigned OUT_W = IMM_OUT_W,
    parameter int unsigned SH_W  = IMM_SH_W
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_data,
    input  logic [IMM_BITS_W-1:0] in_bits,
    input  logic [1:0]            in_mode,
    input  logic [SH_W-1:0]       in_shamt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic                  out_err
`ifdef IMM_EXT_OVF_EN
    ,
    output logic                  out_ovf
`endif
);

    imm_mode_t          mode;
    logic [OUT_W-1:0]   ext_data_c;
    logic               ext_err_c;

    logic               s1_valid;
    logic [OUT_W-1:0]   s1_data;
    logic               s1_err;
    logic               s1_shl;
    logic [SH_W-1:0]    s1_shamt;

    logic               s1_adv;
    logic               s2_adv;
    logic [OUT_W-1:0]   shifted_c;

    assign mode = imm_mode_t'(in_mode);

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .data       (in_data),
        .bits       (in_bits),
        .mode       (mode),
        .ext_data_c (ext_data_c),
        .ext_err_c  (ext_err_c)
    );

    // No skid buffer: acceptance depends combinationally on downstream ready.
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

`ifdef IMM_EXT_OVF_EN
    localparam int unsigned WIDE_W = 2 * OUT_W;

    logic [WIDE_W-1:0] wide;
    logic [OUT_W-1:0]  spill;
    logic [OUT_W-1:0]  spill_mask;
    logic              ovf_c;

    // Bits pushed above OUT_W-1 must all match the result sign, otherwise the value overflowed.
    assign wide       = WIDE_W'(s1_data) << s1_shamt;
    assign shifted_c  = s1_shl ? wide[OUT_W-1:0] : s1_data;
    assign spill      = wide[WIDE_W-1:OUT_W];
    assign spill_mask = ~({OUT_W{1'b1}} << s1_shamt);
    assign ovf_c      = s1_shl && |((spill ^ {OUT_W{wide[OUT_W-1]}}) & spill_mask);
`else
    assign shifted_c  = s1_shl ? (s1_data << s1_shamt) : s1_data;
`endif

    // Stage 1 register: extended value plus what stage 2 needs to finish it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_err   <= 1'b0;
            s1_shl   <= 1'b0;
            s1_shamt <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data  <= ext_data_c;
                s1_err   <= ext_err_c;
                s1_shl   <= imm_is_shift(mode);
                s1_shamt <= in_shamt;
            end
        end
    end

    // Stage 2 register doubles as the output holding register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
`ifdef IMM_EXT_OVF_EN
            out_ovf   <= 1'b0;
`endif
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= shifted_c;
                out_err  <= s1_err;
`ifdef IMM_EXT_OVF_EN
                out_ovf  <= ovf_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe; covers out_ovf when IMM_EXT_OVF_EN is defined.
module tb_imm_extend_pipe;

    localparam int unsigned IN_W  = 27;
    localparam int unsigned OUT_W = 32;
    localparam int unsigned SH_W  = 5;

    typedef struct {
        logic [IN_W-1:0]  data;
        logic [4:0]       bits;
        logic [1:0]       mode;
        logic [SH_W-1:0]  shamt;
        logic [OUT_W-1:0] exp_data;
        logic             exp_err;
        logic             exp_ovf;
    } vec_t;

    logic             clock;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [4:0]       in_bits;
    logic [1:0]       in_mode;
    logic [SH_W-1:0]  in_shamt;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_err;
`ifdef IMM_EXT_OVF_EN
    logic             out_ovf;
`endif

    int total = 0;
    int bad   = 0;

    imm_extend_pipe #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SH_W  (SH_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bits   (in_bits),
        .in_mode   (in_mode),
        .in_shamt  (in_shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
`ifdef IMM_EXT_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic [IN_W-1:0] d, input logic [4:0] b, input logic [1:0] m,
                                input logic [SH_W-1:0] s, input logic [OUT_W-1:0] e,
                                input logic er, input logic ov);
        vec_t v;
        v.data = d; v.bits = b; v.mode = m; v.shamt = s;
        v.exp_data = e; v.exp_err = er; v.exp_ovf = ov;
        return v;
    endfunction

    // Presents one request (caller is #1 past a rising edge, pipe idle) and waits a bounded time for its result.
    task automatic run_one(input vec_t v, output logic [OUT_W-1:0] od, output logic oe,
                           output logic oo, output int lat);
        in_data   = v.data;
        in_bits   = v.bits;
        in_mode   = v.mode;
        in_shamt  = v.shamt;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        od = out_data;
        oe = out_err;
`ifdef IMM_EXT_OVF_EN
        oo = out_ovf;
`else
        oo = 1'b0;
`endif
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_bits   = '0;
        in_mode   = '0;
        in_shamt  = '0;
        out_ready = 1'b0;
        @(posedge clock); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset out_data: got %h want 0", out_data); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset out_err: got %b want 0", out_err); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_extend();
        vec_t v[8];
        logic [OUT_W-1:0] od;
        logic oe, oo;
        int lat;
        v[0] = mk(27'h0010000, 5'd17, 2'b00, 5'd0, 32'hFFFF0000, 1'b0, 1'b0);
        v[1] = mk(27'h7FFFFFF, 5'd27, 2'b01, 5'd0, 32'h07FFFFFF, 1'b0, 1'b0);
        v[2] = mk(27'h5A5A0FF, 5'd8,  2'b00, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        v[3] = mk(27'h5A5A0FF, 5'd8,  2'b01, 5'd0, 32'h000000FF, 1'b0, 1'b0);
        v[4] = mk(27'h0ABC7FF, 5'd12, 2'b00, 5'd0, 32'h000007FF, 1'b0, 1'b0);
        v[5] = mk(27'h0000001, 5'd1,  2'b00, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        v[6] = mk(27'h0000005, 5'd4,  2'b00, 5'd8, 32'h00000005, 1'b0, 1'b0);
        v[7] = mk(27'h4000000, 5'd27, 2'b00, 5'd0, 32'hFC000000, 1'b0, 1'b0);
        @(posedge clock); #1;
        for (int i = 0; i < 8; i++) begin
            run_one(v[i], od, oe, oo, lat);
            total++; if (lat !== 2) begin bad++; $display("FAIL extend[%0d] latency: got %0d want 2", i, lat); end
            total++; if (od !== v[i].exp_data) begin bad++; $display("FAIL extend[%0d] data: got %h want %h", i, od, v[i].exp_data); end
            total++; if (oe !== v[i].exp_err) begin bad++; $display("FAIL extend[%0d] err: got %b want %b", i, oe, v[i].exp_err); end
        end
    endtask

    task automatic test_shift();
        vec_t v[4];
        logic [OUT_W-1:0] od;
        logic oe, oo;
        int lat;
        v[0] = mk(27'h0001234, 5'd16, 2'b10, 5'd16, 32'h12340000, 1'b0, 1'b0);
        v[1] = mk(27'h0000FFF, 5'd12, 2'b10, 5'd4,  32'hFFFFFFF0, 1'b0, 1'b0);
        v[2] = mk(27'h0000003, 5'd2,  2'b10, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0);
        v[3] = mk(27'h0000001, 5'd27, 2'b10, 5'd31, 32'h80000000, 1'b0, 1'b1);
        @(posedge clock); #1;
        for (int i = 0; i < 4; i++) begin
            run_one(v[i], od, oe, oo, lat);
            total++; if (od !== v[i].exp_data) begin bad++; $display("FAIL shift[%0d] data: got %h want %h", i, od, v[i].exp_data); end
            total++; if (oe !== v[i].exp_err) begin bad++; $display("FAIL shift[%0d] err: got %b want %b", i, oe, v[i].exp_err); end
`ifdef IMM_EXT_OVF_EN
            total++; if (oo !== v[i].exp_ovf) begin bad++; $display("FAIL shift[%0d] ovf: got %b want %b", i, oo, v[i].exp_ovf); end
`endif
        end
    endtask

    task automatic test_errors();
        vec_t v[4];
        logic [OUT_W-1:0] od;
        logic oe, oo;
        int lat;
        v[0] = mk(27'h0001234, 5'd16, 2'b11, 5'd3,  32'h00000000, 1'b1, 1'b0);
        v[1] = mk(27'h4000000, 5'd0,  2'b00, 5'd0,  32'hFC000000, 1'b1, 1'b0);
        v[2] = mk(27'h7FFFFFF, 5'd28, 2'b01, 5'd0,  32'h07FFFFFF, 1'b1, 1'b0);
        v[3] = mk(27'h7FFFFFF, 5'd31, 2'b00, 5'd0,  32'hFFFFFFFF, 1'b1, 1'b0);
        @(posedge clock); #1;
        for (int i = 0; i < 4; i++) begin
            run_one(v[i], od, oe, oo, lat);
            total++; if (od !== v[i].exp_data) begin bad++; $display("FAIL errors[%0d] data: got %h want %h", i, od, v[i].exp_data); end
            total++; if (oe !== v[i].exp_err) begin bad++; $display("FAIL errors[%0d] err: got %b want %b", i, oe, v[i].exp_err); end
        end
    endtask

`ifdef IMM_EXT_OVF_EN
    task automatic test_ovf();
        vec_t v[2];
        logic [OUT_W-1:0] od;
        logic oe, oo;
        int lat;
        v[0] = mk(27'h0008000, 5'd16, 2'b10, 5'd17, 32'h00000000, 1'b0, 1'b1);
        v[1] = mk(27'h0008000, 5'd16, 2'b00, 5'd17, 32'hFFFF8000, 1'b0, 1'b0);
        @(posedge clock); #1;
        for (int i = 0; i < 2; i++) begin
            run_one(v[i], od, oe, oo, lat);
            total++; if (od !== v[i].exp_data) begin bad++; $display("FAIL ovf[%0d] data: got %h want %h", i, od, v[i].exp_data); end
            total++; if (oo !== v[i].exp_ovf) begin bad++; $display("FAIL ovf[%0d] ovf: got %b want %b", i, oo, v[i].exp_ovf); end
        end
    endtask
`endif

    // Four requests in consecutive cycles with out_ready high: one result per cycle, two cycles behind.
    task automatic test_back_to_back();
        logic [OUT_W-1:0] e[4];
        logic exp_v;
        e[0] = 32'h0000007E;
        e[1] = 32'h0000007F;
        e[2] = 32'hFFFFFF80;
        e[3] = 32'hFFFFFF81;
        @(posedge clock); #1;
        out_ready = 1'b1;
        in_mode   = 2'b00;
        in_bits   = 5'd8;
        in_shamt  = '0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            in_valid = (cyc < 4);
            in_data  = IN_W'(32'h7E + 32'(cyc));
            @(negedge clock);
            if (cyc < 4) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b in_ready cyc%0d: got %b want 1", cyc, in_ready); end
            end
            exp_v = (cyc >= 2) && (cyc < 6);
            total++; if (out_valid !== exp_v) begin bad++; $display("FAIL b2b out_valid cyc%0d: got %b want %b", cyc, out_valid, exp_v); end
            if (exp_v) begin
                total++; if (out_data !== e[cyc-2]) begin bad++; $display("FAIL b2b data cyc%0d: got %h want %h", cyc, out_data, e[cyc-2]); end
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
    endtask

    // Eight streamed requests with the consumer stalled for the first five cycles.
    task automatic test_backpressure();
        logic [OUT_W-1:0] got[$];
        logic [OUT_W-1:0] held;
        logic holding;
        int n_acc;
        int drop_at;
        n_acc   = 0;
        drop_at = -1;
        holding = 1'b0;
        held    = '0;
        @(posedge clock); #1;
        in_mode   = 2'b01;
        in_bits   = 5'd27;
        in_shamt  = '0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = IN_W'(32'h111);
        for (int cyc = 0; cyc < 60 && got.size() < 8; cyc++) begin
            @(negedge clock);
            if (holding) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    bad++;
                    $display("FAIL bp hold cyc%0d: got valid=%b data=%h want valid=1 data=%h", cyc, out_valid, out_data, held);
                end
            end
            holding = out_valid && !out_ready;
            held    = out_data;
            if (out_valid && out_ready) got.push_back(out_data);
            if (in_valid && !in_ready && drop_at < 0) drop_at = n_acc;
            if (in_valid && in_ready) n_acc++;
            @(posedge clock); #1;
            in_valid  = (n_acc < 8);
            in_data   = IN_W'(32'h111 * 32'(n_acc + 1));
            out_ready = (cyc + 1 >= 5);
        end
        in_valid = 1'b0;
        total++; if (drop_at !== 2) begin bad++; $display("FAIL bp in_ready drop: got after %0d accepts want 2", drop_at); end
        total++; if (n_acc !== 8) begin bad++; $display("FAIL bp accepts: got %0d want 8", n_acc); end
        total++; if (got.size() !== 8) begin bad++; $display("FAIL bp outputs: got %0d want 8", got.size()); end
        for (int k = 0; k < got.size() && k < 8; k++) begin
            total++;
            if (got[k] !== 32'h111 * 32'(k + 1)) begin
                bad++;
                $display("FAIL bp order[%0d]: got %h want %h", k, got[k], 32'h111 * 32'(k + 1));
            end
        end
    endtask

    // Fill both stages, then reset: everything in flight must vanish.
    task automatic test_reset_flush();
        @(posedge clock); #1;
        out_ready = 1'b0;
        in_mode   = 2'b01;
        in_bits   = 5'd27;
        in_shamt  = '0;
        in_valid  = 1'b1;
        in_data   = IN_W'(32'hABC);
        @(posedge clock); #1;
        in_data   = IN_W'(32'hDEF);
        @(posedge clock); #1;
        in_valid  = 1'b0;
        @(negedge clock);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush full in_ready: got %b want 0", in_ready); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush full out_valid: got %b want 1", out_valid); end
        reset_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush out_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush in_ready: got %b want 1", in_ready); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL flush out_data: got %h want 0", out_data); end
        @(negedge clock);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clock);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush stale cyc%0d: got out_valid=%b want 0", cyc, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_extend();
        test_shift();
        test_errors();
`ifdef IMM_EXT_OVF_EN
        test_ovf();
`endif
        test_back_to_back();
        test_backpressure();
        test_reset_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
